// File: rtl/keypad_cntr.sv
// keypad_cntr: 4x4 matrix keypad scanner and debouncer with a rotating active-low column strobe.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid while a key is held (auto-repeat).
module keypad_cntr #(
   parameter int unsigned SCAN_CYCLES  = 100000,
   parameter int unsigned DEB_SAMPLES  = 10,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_value,
   output logic       key_valid,
   output logic       key_pressed
);

   localparam int unsigned DWELL_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned DEB_W   = (DEB_SAMPLES > 2) ? $clog2(DEB_SAMPLES) : 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_SAMPLES - 1);
   localparam logic [DEB_W-1:0]   DEB_PRE    = DEB_W'(DEB_SAMPLES - 2);

   // Reject configurations below the documented minimums at elaboration.
   if (SCAN_CYCLES < 4 || DEB_SAMPLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      $error("keypad_cntr: parameter below its minimum");
   end

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         sync1_q, rs_q;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [3:0]         col_q, col_d;
   logic [1:0]         cidx_q, cidx_d;
   logic [1:0]         ridx_q, ridx_d;
   logic [DEB_W-1:0]   deb_q, deb_d;
   logic [DEB_W-1:0]   rel_q, rel_d;
   logic [3:0]         key_value_q, key_value_d;
   logic               key_valid_q, key_valid_d;
   logic               key_pressed_q, key_pressed_d;

   logic               sample_c;
   logic               row_low_c;
   logic               rotate_c;
   logic [1:0]         first_row_c;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_RATE);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [HOLD_W-1:0] hold_inc_c;
   logic              rep_q, rep_d;

   assign hold_inc_c = hold_q + HOLD_W'(1);
`endif

   assign sample_c  = (dwell_q == DWELL_LAST);
   assign row_low_c = ~rs_q[ridx_q];

   // Lowest-indexed low row wins when several rows return at once.
   always_comb begin
      first_row_c = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rs_q[i]) first_row_c = 2'(i);
      end
   end

   always_comb begin
      state_d       = state_q;
      dwell_d       = sample_c ? '0 : dwell_q + DWELL_W'(1);
      col_d         = col_q;
      cidx_d        = cidx_q;
      ridx_d        = ridx_q;
      deb_d         = deb_q;
      rel_d         = rel_q;
      key_value_d   = key_value_q;
      key_valid_d   = 1'b0;
      key_pressed_d = key_pressed_q;
      rotate_c      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_d        = hold_q;
      rep_d         = rep_q;
`endif

      case (state_q)
         SCAN: begin
            if (sample_c) begin
               if (rs_q == 4'hF) begin
                  rotate_c = 1'b1;
               end else begin
                  ridx_d  = first_row_c;
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end
            end
         end

         DEBOUNCE: begin
            if (sample_c) begin
               if (row_low_c) begin
                  deb_d = deb_q + DEB_W'(1);
                  if (deb_q == DEB_PRE) begin
                     state_d       = PRESSED;
                     key_value_d   = {ridx_q, cidx_q};
                     key_valid_d   = 1'b1;
                     key_pressed_d = 1'b1;
                     rel_d         = '0;
`ifdef KEYPAD_REPEAT_EN
                     hold_d        = '0;
                     rep_d         = 1'b0;
`endif
                  end
               end else begin
                  state_d  = SCAN;
                  rotate_c = 1'b1;
               end
            end
         end

         PRESSED: begin
            if (sample_c) begin
               if (!row_low_c) begin
`ifdef KEYPAD_REPEAT_EN
                  hold_d = '0;
                  rep_d  = 1'b0;
`endif
                  if (rel_q == DEB_LAST) begin
                     key_pressed_d = 1'b0;
                     rel_d         = '0;
                     state_d       = SCAN;
                     rotate_c      = 1'b1;
                  end else begin
                     rel_d = rel_q + DEB_W'(1);
                  end
               end else begin
                  rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
                  // First repeat after REPEAT_DELAY held samples, then every REPEAT_RATE.
                  if ((!rep_q && hold_inc_c == HOLD_FIRST) || (rep_q && hold_inc_c == HOLD_NEXT)) begin
                     key_valid_d = 1'b1;
                     hold_d      = '0;
                     rep_d       = 1'b1;
                  end else begin
                     hold_d = hold_inc_c;
                  end
`endif
               end
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase

      if (rotate_c) begin
         col_d  = {col_q[2:0], col_q[3]};
         cidx_d = cidx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= SCAN;
         sync1_q       <= 4'hF;
         rs_q          <= 4'hF;
         dwell_q       <= '0;
         col_q         <= 4'b1110;
         cidx_q        <= 2'd0;
         ridx_q        <= 2'd0;
         deb_q         <= '0;
         rel_q         <= '0;
         key_value_q   <= 4'd0;
         key_valid_q   <= 1'b0;
         key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         hold_q        <= '0;
         rep_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         sync1_q       <= row;
         rs_q          <= sync1_q;
         dwell_q       <= dwell_d;
         col_q         <= col_d;
         cidx_q        <= cidx_d;
         ridx_q        <= ridx_d;
         deb_q         <= deb_d;
         rel_q         <= rel_d;
         key_value_q   <= key_value_d;
         key_valid_q   <= key_valid_d;
         key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
         hold_q        <= hold_d;
         rep_q         <= rep_d;
`endif
      end
   end

   assign col         = col_q;
   assign key_value   = key_value_q;
   assign key_valid   = key_valid_q;
   assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_cntr.sv
// tb_keypad_cntr: self-checking bench for keypad_cntr with a physical key-matrix model
// and a sample-level behavioural reference model.
module tb_keypad_cntr;

   localparam int SCAN_CYCLES  = 4;
   localparam int DEB_SAMPLES  = 3;
   localparam int REPEAT_DELAY = 5;
   localparam int REPEAT_RATE  = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_value;
   logic        key_valid;
   logic        key_pressed;
   logic [15:0] keys;

   int errors = 0;
   int checks = 0;
   int nvalid = 0;

   // Reference model state, one update per sample point.
   int m_col, m_row, m_run, m_value, m_hold;
   bit m_locked, m_held, m_pressed, m_valid, m_rep;

   typedef struct {
      int r;
      int c;
      int hold;
      int exp_valids;
      int exp_value;
   } vec_t;

   vec_t vecs [8];

   keypad_cntr #(
      .SCAN_CYCLES (SCAN_CYCLES),
      .DEB_SAMPLES (DEB_SAMPLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .row        (row),
      .col        (col),
      .key_value  (key_value),
      .key_valid  (key_valid),
      .key_pressed(key_pressed)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column; a row reads low when any key on an active column is down.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_col = 0; m_row = 0; m_run = 0; m_value = 0; m_hold = 0;
      m_locked = 0; m_held = 0; m_pressed = 0; m_valid = 0; m_rep = 0;
   endtask

   task automatic model_sample();
      int low;
      bit lowrow;
      m_valid = 0;
      low = 0;
      for (int r = 0; r < 4; r++) if (keys[r*4+m_col]) low |= (1 << r);
      if (!m_locked) begin
         if (low == 0) begin
            m_col = (m_col + 1) % 4;
         end else begin
            m_locked = 1;
            for (int r = 3; r >= 0; r--) if (((low >> r) & 1) != 0) m_row = r;
            m_run = 1;
         end
      end else begin
         lowrow = ((low >> m_row) & 1) != 0;
         if (!m_held) begin
            if (lowrow) begin
               m_run++;
               if (m_run == DEB_SAMPLES) begin
                  m_held = 1; m_valid = 1; m_pressed = 1;
                  m_value = m_row * 4 + m_col;
                  m_run = 0; m_hold = 0; m_rep = 0;
               end
            end else begin
               m_locked = 0;
               m_col = (m_col + 1) % 4;
            end
         end else if (!lowrow) begin
            m_run++; m_hold = 0; m_rep = 0;
            if (m_run == DEB_SAMPLES) begin
               m_held = 0; m_locked = 0; m_pressed = 0; m_run = 0;
               m_col = (m_col + 1) % 4;
            end
         end else begin
            m_run = 0;
`ifdef KEYPAD_REPEAT_EN
            m_hold++;
            if (m_hold == (m_rep ? REPEAT_RATE : REPEAT_DELAY)) begin
               m_valid = 1; m_hold = 0; m_rep = 1;
            end
`endif
         end
      end
   endtask

   task automatic check_outputs(input bit last);
      logic [3:0] exp_col;
      exp_col = 4'hF ^ (4'h1 << m_col);
      if (key_valid) nvalid++;
      check("col", int'(col), int'(exp_col));
      check("key_valid", int'(key_valid), int'(last && m_valid));
      check("key_pressed", int'(key_pressed), int'(m_pressed));
      check("key_value", int'(key_value), m_value);
   endtask

   // One sample period: four clocks, outputs checked 1 time unit after every edge.
   task automatic step();
      for (int i = 1; i <= SCAN_CYCLES; i++) begin
         @(posedge clk);
         #1;
         if (i == SCAN_CYCLES) model_sample();
         check_outputs(i == SCAN_CYCLES);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " col"}, int'(col), 14);
      check({tag, " key_valid"}, int'(key_valid), 0);
      check({tag, " key_pressed"}, int'(key_pressed), 0);
      check({tag, " key_value"}, int'(key_value), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      keys = '0;
      #1;
      check_reset_values("reset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_col(input int c);
      for (int k = 0; k < 8 && m_col != c; k++) step();
      check("wait_col", m_col, c);
   endtask

   task automatic run_vec(input vec_t v);
      int nv0;
      keys = '0;
      wait_col(v.c);
      nv0 = nvalid;
      keys = 16'h1 << (v.r * 4 + v.c);
      repeat (v.hold) step();
      keys = '0;
      repeat (DEB_SAMPLES + 2) step();
      check("vec valids", nvalid - nv0, v.exp_valids);
      check("vec value", int'(key_value), v.exp_value);
      check("vec released", int'(key_pressed), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] col_seq [4];
      bit         bounce [5];
      int         nv0, a, b, k;

      reset_n = 1'b0;
      keys = '0;
      model_reset();

      vecs[0] = '{r: 2, c: 1, hold: 20, exp_valids: 1, exp_value: 9};
`ifdef KEYPAD_REPEAT_EN
      vecs[0].exp_valids = 8;
`endif
      vecs[1] = '{r: 0, c: 0, hold: 2,  exp_valids: 0, exp_value: 9};
      vecs[2] = '{r: 0, c: 0, hold: 3,  exp_valids: 1, exp_value: 0};
      vecs[3] = '{r: 3, c: 3, hold: 1,  exp_valids: 0, exp_value: 0};
      vecs[4] = '{r: 3, c: 3, hold: 5,  exp_valids: 1, exp_value: 15};
      vecs[5] = '{r: 1, c: 2, hold: 2,  exp_valids: 0, exp_value: 15};
      vecs[6] = '{r: 1, c: 2, hold: 4,  exp_valids: 1, exp_value: 6};
      vecs[7] = '{r: 2, c: 3, hold: 3,  exp_valids: 1, exp_value: 11};

      col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;
      bounce[0] = 0; bounce[1] = 1; bounce[2] = 0; bounce[3] = 0; bounce[4] = 0;

      do_reset();

      // Idle scan: column advances on every fourth clock after reset release.
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(posedge clk);
         #1;
         check("idle col", int'(col), int'(col_seq[(cyc / 4) % 4]));
         check("idle key_valid", int'(key_valid), 0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Two rows low on column 0: row 1 takes priority over row 3.
      keys = '0;
      wait_col(0);
      keys = (16'h1 << 4) | (16'h1 << 12);
      repeat (DEB_SAMPLES) step();
      check("ghost value", int'(key_value), 4);
      check("ghost pressed", int'(key_pressed), 1);
      keys = '0;
      repeat (DEB_SAMPLES + 2) step();

      // Release bounce: high, low, high, high, high.
      wait_col(2);
      keys = 16'h1 << 2;
      repeat (DEB_SAMPLES) step();
      check("bounce accepted", int'(key_pressed), 1);
      nv0 = nvalid;
      for (int i = 0; i < 5; i++) begin
         keys = bounce[i] ? (16'h1 << 2) : 16'h0;
         step();
         check("bounce pressed", int'(key_pressed), (i < 4) ? 1 : 0);
      end
      check("bounce extra valid", nvalid - nv0, 0);

      // Asynchronous reset while a key is held.
      wait_col(3);
      keys = 16'h1 << 7;
      repeat (DEB_SAMPLES + 1) step();
      check("pre-reset pressed", int'(key_pressed), 1);
      do_reset();

      // Randomised key activity against the reference model.
      for (int it = 0; it < 200; it++) begin
         k = int'($urandom_range(0, 9));
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         if (k < 2)      keys = '0;
         else if (k < 8) keys = 16'h1 << a;
         else            keys = (16'h1 << a) | (16'h1 << b);
         repeat (int'($urandom_range(1, 8))) step();
         keys = '0;
         repeat (int'($urandom_range(0, 5))) step();
      end
      keys = '0;
      repeat (DEB_SAMPLES + 2) step();
      check("final released", int'(key_pressed), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
